// File: rtl/tl_bridge_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tl_bridge_emulator
// Brief    : TileLink-UL master that runs a write-then-readback sweep, checks
//            every D response and drives core status/interrupt lines.
// Revision : 1.0
// ============================================================================
module tl_bridge_emulator #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int SRC_W        = 2,
    parameter int CNT_W        = 8,
    parameter int HART_W       = 2,
    parameter int TIMER_PERIOD = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [CNT_W-1:0]    cfg_count,
    input  logic [HART_W-1:0]   hartid,
    output logic                a_valid,
    output logic [2:0]          a_opcode,
    output logic [2:0]          a_param,
    output logic [3:0]          a_size,
    output logic [SRC_W-1:0]    a_source,
    output logic [ADDR_W-1:0]   a_address,
    output logic [DATA_W/8-1:0] a_mask,
    output logic [DATA_W-1:0]   a_data,
    output logic                a_corrupt,
    input  logic                a_ready,
    input  logic                d_valid,
    input  logic [2:0]          d_opcode,
    input  logic [1:0]          d_param,
    input  logic [3:0]          d_size,
    input  logic [SRC_W-1:0]    d_source,
    input  logic [2:0]          d_sink,
    input  logic                d_denied,
    input  logic [DATA_W-1:0]   d_data,
    input  logic                d_corrupt,
    output logic                d_ready,
    output logic                busy,
    output logic                done,
    output logic [15:0]         err_count,
    output logic                wfi,
    output logic                debug,
    output logic                mtip,
    output logic                msip,
    output logic                meip,
    output logic                seip
);

    localparam int BYTES   = DATA_W / 8;
    localparam int SIZE_LG = $clog2(BYTES);
    localparam int NSRC    = 1 << SRC_W;

    typedef enum logic [1:0] {S_IDLE, S_PUT, S_GET, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [HART_W-1:0]       hart_q, hart_d;
    logic [CNT_W-1:0]        issue_q, issue_d;
    logic [NSRC-1:0]         inflight_q, inflight_d;
    logic                    a_valid_q, a_valid_d;
    logic [SRC_W-1:0]        a_src_q, a_src_d;
    logic [CNT_W-1:0]        a_idx_q, a_idx_d;
    logic [15:0]             err_q, err_d;
    logic [CNT_W-1:0]        tbl_q [NSRC];

    logic                    active, beats_left, alloc, found, d_fire, d_bad;
    logic [NSRC-1:0]         free_mask;
    logic [SRC_W-1:0]        alloc_src;
    logic                    unused_d;

    function automatic logic [DATA_W-1:0] pattern(input logic [HART_W-1:0] h,
                                                  input logic [CNT_W-1:0]  i);
        return DATA_W'({h, i});
    endfunction

    assign unused_d = ^{d_param, d_size, d_sink};

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        hart_d     = hart_q;
        issue_d    = issue_q;
        inflight_d = inflight_q;
        a_valid_d  = a_valid_q;
        a_src_d    = a_src_q;
        a_idx_d    = a_idx_q;
        err_d      = err_q;
        alloc_src  = '0;
        found      = 1'b0;
        d_bad      = 1'b0;

        active     = (state_q == S_PUT) || (state_q == S_GET);
        beats_left = (issue_q != count_q);
        // The source currently presented on A is not yet in flight but is taken.
        free_mask  = ~inflight_q & ~(a_valid_q ? (NSRC'(1) << a_src_q) : '0);
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                alloc_src = SRC_W'(i);
                found     = 1'b1;
            end
        end
        alloc  = active && beats_left && found && (!a_valid_q || a_ready);
        d_fire = d_valid && (state_q != S_IDLE);

        if (a_valid_q && a_ready) begin
            inflight_d = inflight_d | (NSRC'(1) << a_src_q);
            a_valid_d  = 1'b0;
        end
        if (alloc) begin
            a_valid_d = 1'b1;
            a_src_d   = alloc_src;
            a_idx_d   = issue_q;
            issue_d   = issue_q + 1'b1;
        end

        if (d_fire) begin
            if (inflight_q[d_source]) begin
                inflight_d = inflight_d & ~(NSRC'(1) << d_source);
            end
            d_bad = !inflight_q[d_source] || d_denied || d_corrupt
                 || ((state_q == S_GET) ? (d_opcode != 3'd1) : (d_opcode != 3'd0))
                 || ((state_q == S_GET) && (d_data != pattern(hart_q, tbl_q[d_source])));
            if (d_bad && (err_q != 16'hFFFF)) begin
                err_d = err_q + 16'd1;
            end
        end

        if (active && !beats_left && !a_valid_q && (inflight_q == '0)) begin
            state_d = (state_q == S_PUT) ? S_GET : S_DONE;
            issue_d = '0;
        end

        if (start && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
            base_d     = cfg_base;
            count_d    = cfg_count;
            hart_d     = hartid;
            issue_d    = '0;
            inflight_d = '0;
            err_d      = '0;
            state_d    = (cfg_count == '0) ? S_DONE : S_PUT;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            hart_q     <= '0;
            issue_q    <= '0;
            inflight_q <= '0;
            a_valid_q  <= 1'b0;
            a_src_q    <= '0;
            a_idx_q    <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            hart_q     <= hart_d;
            issue_q    <= issue_d;
            inflight_q <= inflight_d;
            a_valid_q  <= a_valid_d;
            a_src_q    <= a_src_d;
            a_idx_q    <= a_idx_d;
            err_q      <= err_d;
        end
    end

    // Beat index per source, used to rebuild the expected readback pattern.
    always_ff @(posedge clock) begin
        if (alloc) begin
            tbl_q[alloc_src] <= issue_q;
        end
    end

    assign a_valid   = a_valid_q;
    assign a_opcode  = (a_valid_q && (state_q == S_GET)) ? 3'd4 : 3'd0;
    assign a_param   = 3'd0;
    assign a_size    = a_valid_q ? 4'(SIZE_LG) : 4'd0;
    assign a_source  = a_valid_q ? a_src_q : '0;
    assign a_address = a_valid_q ? (base_q + (ADDR_W'(a_idx_q) << SIZE_LG)) : '0;
    assign a_mask    = a_valid_q ? '1 : '0;
    assign a_data    = (a_valid_q && (state_q == S_PUT)) ? pattern(hart_q, a_idx_q) : '0;
    assign a_corrupt = 1'b0;

    assign d_ready   = (state_q != S_IDLE);
    assign busy      = active;
    assign done      = (state_q == S_DONE);
    assign err_count = err_q;
    assign wfi       = done;
    assign meip      = done && (err_q != 16'd0);
    assign debug     = 1'b0;
    assign msip      = 1'b0;
    assign seip      = 1'b0;

    generate
        if (TIMER_PERIOD == 0) begin : g_no_timer
            assign mtip = 1'b0;
        end else begin : g_timer
            localparam int TW = (TIMER_PERIOD > 1) ? $clog2(TIMER_PERIOD) : 1;
            logic [TW-1:0] tmr_q;
            logic          mtip_q;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    tmr_q  <= '0;
                    mtip_q <= 1'b0;
                end else begin
                    tmr_q  <= (tmr_q == TW'(TIMER_PERIOD - 1)) ? '0 : tmr_q + 1'b1;
                    mtip_q <= (tmr_q == TW'(TIMER_PERIOD - 1));
                end
            end
            assign mtip = mtip_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tl_bridge_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_bridge_emulator
// Brief    : Directed bench with a behavioural TileLink-UL memory slave.
// Revision : 1.0
// ============================================================================
module tb_tl_bridge_emulator;

    logic        clock, reset, start;
    logic [31:0] cfg_base;
    logic [7:0]  cfg_count;
    logic [1:0]  hartid;
    logic        a_valid, a_corrupt, a_ready;
    logic [2:0]  a_opcode, a_param;
    logic [3:0]  a_size;
    logic [1:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        d_valid, d_denied, d_corrupt, d_ready;
    logic [2:0]  d_opcode, d_sink;
    logic [1:0]  d_param, d_source;
    logic [3:0]  d_size;
    logic [63:0] d_data;
    logic        busy, done, wfi, debug, mtip, msip, meip, seip;
    logic [15:0] err_count;

    tl_bridge_emulator #(
        .ADDR_W(32), .DATA_W(64), .SRC_W(2), .CNT_W(8), .HART_W(2), .TIMER_PERIOD(16)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .cfg_base(cfg_base),
        .cfg_count(cfg_count), .hartid(hartid),
        .a_valid(a_valid), .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
        .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .a_corrupt(a_corrupt), .a_ready(a_ready),
        .d_valid(d_valid), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
        .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied), .d_data(d_data),
        .d_corrupt(d_corrupt), .d_ready(d_ready),
        .busy(busy), .done(done), .err_count(err_count),
        .wfi(wfi), .debug(debug), .mtip(mtip), .msip(msip), .meip(meip), .seip(seip)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    typedef struct {
        logic [1:0]  src;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [63:0] data;
        int          due;
    } req_t;
    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  src;
        bit          fields_ok;
    } log_t;

    req_t         rq[$];
    log_t         lg[$];
    logic [63:0]  mem [logic [31:0]];
    int           lat = 0, stall_left = 0, stall_seen = 0, viol = 0;
    int           outstanding = 0, max_out = 0, cyc = 0;
    bit           corrupt_en = 0, deny_en = 0, inject = 0, d_real = 0, prev_pend = 0;
    logic [31:0]  corrupt_addr = '0, deny_addr = '0;
    logic [116:0] saved = '0;

    always @(negedge clock) begin
        req_t r;
        log_t l;
        cyc++;
        if (!reset) begin
            rq.delete();
            a_ready = 1'b1; d_valid = 1'b0; d_real = 0;
            outstanding = 0; prev_pend = 0;
        end else begin
            if (d_valid && d_ready && d_real) outstanding--;
            d_valid = 1'b0; d_denied = 1'b0; d_corrupt = 1'b0; d_data = '0;
            d_opcode = '0; d_source = '0; d_real = 0;
            if (prev_pend && (a_valid !== 1'b1 || {a_opcode, a_param, a_size, a_source,
                a_address, a_mask, a_data, a_corrupt} !== saved)) viol++;
            if (a_valid && stall_left > 0) begin
                a_ready = 1'b0; stall_left--; stall_seen++;
            end else begin
                a_ready = 1'b1;
            end
            if (a_valid && a_ready) begin
                r.src = a_source; r.op = a_opcode; r.addr = a_address;
                r.data = a_data; r.due = cyc + lat + 1;
                rq.push_back(r);
                l.op = a_opcode; l.addr = a_address; l.data = a_data; l.src = a_source;
                l.fields_ok = (a_size == 4'd3) && (a_mask == 8'hFF) &&
                              (a_param == 3'd0) && (a_corrupt == 1'b0);
                lg.push_back(l);
                if (a_opcode == 3'd0) mem[a_address] = a_data;
                outstanding++;
                if (outstanding > max_out) max_out = outstanding;
            end
            prev_pend = a_valid && !a_ready;
            saved = {a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt};
            if (inject) begin
                d_valid = 1'b1; d_source = 2'd3; d_opcode = 3'd0; inject = 0;
            end else if (rq.size() > 0 && rq[0].due <= cyc) begin
                r = rq.pop_front();
                d_valid = 1'b1; d_source = r.src; d_real = 1;
                if (r.op == 3'd4) begin
                    d_opcode = 3'd1;
                    d_data = mem.exists(r.addr) ? mem[r.addr] : 64'd0;
                    if (corrupt_en && r.addr == corrupt_addr) d_data = d_data ^ 64'h1;
                end else begin
                    d_opcode = 3'd0;
                    d_denied = deny_en && (r.addr == deny_addr);
                end
            end
        end
    end

    task automatic kick(input logic [31:0] base, input logic [7:0] cnt, input logic [1:0] h);
        @(negedge clock);
        cfg_base = base; cfg_count = cnt; hartid = h; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < maxc) begin
            @(negedge clock);
            n++;
        end
        check(tag, done, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit found;
        reset = 1'b0; start = 1'b0; cfg_base = '0; cfg_count = '0; hartid = '0;
        a_ready = 1'b1; d_valid = 1'b0; d_opcode = '0; d_param = '0; d_size = 4'd3;
        d_source = '0; d_sink = '0; d_denied = 1'b0; d_data = '0; d_corrupt = 1'b0;

        repeat (3) @(negedge clock);
        check("reset_flags", {a_valid, d_ready, busy, done, wfi, meip, mtip, debug, msip, seip}, 0);
        check("reset_err", err_count, 0);
        check("reset_afields", {a_size, a_mask, a_address, a_opcode}, 0);

        // Timer: release reset on a falling edge, then count rising edges.
        reset = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            check($sformatf("mtip_c%0d", k), mtip, (k == 16 || k == 32));
        end

        // Ideal slave
        lg.delete();
        kick(32'h8000_0000, 8'd4, 2'd1);
        wait_done(200, "ideal_done");
        check("ideal_nbeats", lg.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ideal_addr%0d", i), lg[i].addr, 32'h8000_0000 + 32'((i % 4) * 8));
            check($sformatf("ideal_op%0d", i), lg[i].op, (i < 4) ? 3'd0 : 3'd4);
            check($sformatf("ideal_data%0d", i), lg[i].data, (i < 4) ? 64'h100 + 64'(i) : 64'd0);
            check($sformatf("ideal_fields%0d", i), lg[i].fields_ok, 1);
        end
        check("ideal_err", err_count, 0);
        check("ideal_status", {busy, wfi, meip, d_ready}, 4'b0101);

        // A-channel back-pressure on the first beat
        lg.delete(); stall_left = 5; stall_seen = 0; viol = 0;
        kick(32'h0000_1000, 8'd2, 2'd0);
        wait_done(200, "stall_done");
        check("stall_cycles", stall_seen, 5);
        check("stall_stable", viol, 0);
        check("stall_nbeats", lg.size(), 4);
        check("stall_addr0", lg[0].addr, 32'h1000);
        check("stall_addr1", lg[1].addr, 32'h1008);
        check("stall_err", err_count, 0);

        // Long D latency, outstanding limit
        lg.delete(); lat = 20; max_out = 0;
        kick(32'h0000_2000, 8'd8, 2'd3);
        wait_done(600, "lat_done");
        check("lat_maxout", max_out, 4);
        for (int i = 0; i < 4; i++) check($sformatf("lat_src%0d", i), lg[i].src, i);
        check("lat_nbeats", lg.size(), 16);
        check("lat_err", err_count, 0);

        // Corrupted readback of beat 2, denied Put of beat 5
        lat = 0; corrupt_en = 1; corrupt_addr = 32'h3010; deny_en = 1; deny_addr = 32'h3028;
        kick(32'h0000_3000, 8'd6, 2'd2);
        wait_done(300, "errs_done");
        check("errs_count", err_count, 2);
        check("errs_meip", {meip, wfi}, 2'b11);
        corrupt_en = 0; deny_en = 0;

        // Zero-beat sweep finishes immediately and clears the error count
        kick(32'h0000_0000, 8'd0, 2'd0);
        check("zero_status", {done, busy, meip}, 3'b100);
        check("zero_err", err_count, 0);

        // Unknown-source response during PUT; restart while busy is ignored
        lg.delete(); lat = 10;
        kick(32'h0000_4000, 8'd2, 2'd0);
        repeat (2) @(negedge clock);
        check("inj_busy", busy, 1);
        inject = 1;
        @(negedge clock);
        cfg_base = 32'h9000; cfg_count = 8'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(300, "inj_done");
        check("inj_err", err_count, 1);
        check("inj_nbeats", lg.size(), 4);
        check("inj_addr2", lg[2].addr, 32'h4000);
        check("inj_addr3", lg[3].addr, 32'h4008);

        // Asynchronous reset in the middle of GET
        lat = 3;
        kick(32'h0000_5000, 8'd8, 2'd1);
        found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clock);
            if (a_valid === 1'b1 && a_opcode === 3'd4) found = 1;
        end
        check("mid_get_seen", found, 1);
        #2 reset = 1'b0;
        #1;
        check("rst_flags", {a_valid, d_ready, busy, done, wfi, meip, mtip}, 0);
        check("rst_afields", {a_opcode, a_size, a_address, a_mask, a_data}, 0);
        check("rst_err", err_count, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("post_rst_idle", {busy, done, d_ready, a_valid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tl_bridge_emulator.md
Name: tl_bridge_emulator

Overview:
- Parametrised TileLink-UL master emulator that replaces the tied-off bridge stub in tile-less test harnesses.
- Runs a scripted write-then-readback sweep over a memory window, with up to 2^SRC_W requests outstanding.
- Checks every D-channel response and counts errors.
- Drives the core-side status and interrupt outputs (wfi, mtip, meip) from its own state rather than holding them at zero.

Parameters:
- ADDR_W, 32, A-channel address width.
- DATA_W, 64, data bus width; power of 2, ≥ 8.
- SRC_W, 2, source ID width; maximum outstanding requests = 2^SRC_W.
- CNT_W, 8, width of the beat-count configuration.
- HART_W, 2, hartid width.
- TIMER_PERIOD, 1024, number of cycles between mtip assertions; 0 disables the timer.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a sweep (honoured only in IDLE or DONE).
- cfg_base  in  ADDR_W  sweep base address; must be DATA_W/8-aligned.
- cfg_count  in  CNT_W  number of beats; 0 means an immediate DONE.
- hartid  in  HART_W  embedded in the data pattern.
- a_valid, a_opcode[3], a_param[3], a_size[4], a_source[SRC_W], a_address[ADDR_W], a_mask[DATA_W/8], a_data[DATA_W], a_corrupt  out  TL A channel.
- a_ready  in  1  TL A channel ready.
- d_valid, d_opcode[3], d_param[2], d_size[4], d_source[SRC_W], d_sink[3], d_denied, d_data[DATA_W], d_corrupt  in  TL D channel.
- d_ready  out  1  TL D channel ready.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; held high until the next start.
- err_count  out  16  errors seen this sweep; saturating.
- wfi, debug, mtip, msip, meip, seip  out  1 each  core status and interrupt lines.

Behaviour:
- Reset (reset=0): FSM=IDLE; all outputs 0, including d_ready, a_valid and err_count; source bitmap all free; timer=0.
- FSM states:
  - IDLE --start--> PUT, with cfg_base, cfg_count and hartid latched.
  - PUT --(all cfg_count beats issued and all Put acks returned)--> GET.
  - GET --(all beats issued and all acks returned)--> DONE.
  - DONE --start--> PUT.
  - start with cfg_count=0 → DONE on the next cycle.
  - start outside IDLE/DONE is ignored.
- Beat i:
  - address = base + i*(DATA_W/8);
  - pattern = {hartid, i} zero-extended to DATA_W;
  - a_size = log2(DATA_W/8);
  - a_mask all ones; a_param=0; a_corrupt=0.
- PUT issues opcode 0 (PutFullData) with a_data=pattern. GET issues opcode 4 (Get) with a_data=0.
- Source allocation:
  - a_valid is asserted only when a beat remains and a source is free.
  - The lowest free source is chosen; its beat index is recorded in a per-source table.
  - Once a_valid is high, a_valid and all A fields are held stable until a_ready. There is no combinational path from a_ready to a_valid.
  - A source is marked in flight on the a_valid&a_ready cycle.
- d_ready = 1 in every state except IDLE.
- On d_valid&d_ready, the source is freed that cycle. A freed source may be reallocated on the following cycle, not the same cycle.
- Error conditions (err_count += 1 per offending beat, saturating at 0xFFFF):
  - d_denied or d_corrupt;
  - opcode ≠ 0 in PUT or ≠ 1 (AccessAckData) in GET;
  - in GET, d_data ≠ pattern(table[d_source]);
  - d_source not in flight. The response is dropped and the bitmap is unchanged.
- busy = (state is PUT or GET). done = (state is DONE). err_count is cleared on an accepted start.
- wfi = done. meip = done & (err_count≠0). debug = msip = seip = 0.
- Timer: free-running count of 0..TIMER_PERIOD-1. mtip pulses high for one cycle at wrap. With TIMER_PERIOD=0, mtip stays 0.
- Reset asserted mid-sweep: everything returns to reset values immediately. In-flight responses arriving after reset release are treated as unknown-source errors only if state≠IDLE; in IDLE they are dropped silently because d_ready=0.

Test Plan:
- Reset, then start with base=0x8000_0000, count=4, hartid=1, and an ideal slave (a_ready=1, zero-latency correct D) → 4 Puts at 0x8000_0000/08/10/18, then 4 Gets; done=1, err_count=0, wfi=1, meip=0.
- Slave holds a_ready=0 for 5 cycles on the first beat → A fields stable throughout; a single handshake; beat count unaffected.
- Slave with D latency 20 cycles and SRC_W=2, count=8 → never more than 4 outstanding; sources 0,1,2,3 are used first; completes with err_count=0.
- Slave corrupts the GET data for beat 2 and sets d_denied on the Put of beat 5, with count=6 → err_count=2, meip=1 once done.
- Inject d_valid with a non-in-flight source during PUT → err_count=1; the bitmap is unchanged; the sweep still completes.
- TIMER_PERIOD=16, then run idle for 40 cycles → mtip high exactly at cycles 16 and 32 after reset release; deassert reset mid-GET → all outputs 0 the same cycle.
